max_pooling_layer: RTL and testbench

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of `convolutional_layer`. It consumes that layer's raster-ordered multi-channel pixel stream (`output_data`/`valid`) and emits one pooled pixel per non-overlapping 2×2 window. Its output is itself a raster stream with a valid qualifier, so it can feed a further convolutional or fully-connected stage. Pooling is per channel, unsigned, with no arithmetic growth.

---
 rtl/max_pooling_layer.sv | 134 +++++++++++++
 tb/tb_max_pooling_layer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/max_pooling_layer.sv
// rtl/max_pooling_layer.sv - streaming 2x2 stride-2 per-channel unsigned max-pooling stage
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   clk_en       global enable; all registers hold when low
//   input_valid  input_data carries a raster-ordered pixel this cycle
//   input_data   CHANNELS x D_WIDTH pixel, channel k at [k*D_WIDTH +: D_WIDTH]
//   output_data  pooled pixel, same channel packing, holds between outputs
//   valid        one-cycle pulse per pooled pixel (stretched while clk_en is low)
//   last         high with valid for the final pooled pixel of a frame
module max_pooling_layer #(
    parameter int D_WIDTH    = 16,
    parameter int CHANNELS   = 3,
    parameter int IMAGE_SIZE = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        input_valid,
    input  logic [CHANNELS*D_WIDTH-1:0] input_data,
    output logic [CHANNELS*D_WIDTH-1:0] output_data,
    output logic                        valid,
    output logic                        last
);

    localparam int PW   = CHANNELS * D_WIDTH;
    localparam int CW   = (IMAGE_SIZE > 2) ? $clog2(IMAGE_SIZE) : 1;
    localparam int HALF = IMAGE_SIZE / 2;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] EDGE_IDX = CW'(IMAGE_SIZE - 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] h_q, h_d;
    logic [PW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    // Holds the horizontal pair maxima of the most recent even row.
    logic [PW-1:0] line_buf [HALF];

    logic          accept;
    logic          buf_we;
    logic [BW-1:0] buf_idx;
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] pair_max;
    logic [PW-1:0] pool_max;

    function automatic logic [D_WIDTH-1:0] umax(input logic [D_WIDTH-1:0] a,
                                                input logic [D_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign accept  = clk_en & input_valid;
    assign buf_idx = BW'(col_q >> 1);
    assign buf_rd  = line_buf[buf_idx];
    assign buf_we  = accept & ~row_q[0] & col_q[0];

    always_comb begin
        pair_max = '0;
        pool_max = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pair_max[k*D_WIDTH +: D_WIDTH] = umax(h_q[k*D_WIDTH +: D_WIDTH],
                                                  input_data[k*D_WIDTH +: D_WIDTH]);
            pool_max[k*D_WIDTH +: D_WIDTH] = umax(pair_max[k*D_WIDTH +: D_WIDTH],
                                                  buf_rd[k*D_WIDTH +: D_WIDTH]);
        end
    end

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        h_d     = h_q;
        out_d   = out_q;
        valid_d = valid_q;
        last_d  = last_q;

        // The pulse ends on any enabled edge, bubble or not.
        if (clk_en) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (accept) begin
            if (!col_q[0]) begin
                h_d = input_data;
            end

            if (col_q == EDGE_IDX) begin
                col_d = '0;
                row_d = (row_q == EDGE_IDX) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (row_q[0] && col_q[0]) begin
                out_d   = pool_max;
                valid_d = 1'b1;
                last_d  = (row_q == EDGE_IDX) && (col_q == EDGE_IDX);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            h_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            h_q     <= h_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[buf_idx] <= pair_max;
        end
    end

    assign output_data = out_q;
    assign valid       = valid_q;
    assign last        = last_q;

endmodule

// File: tb/tb_max_pooling_layer.sv
// tb/tb_max_pooling_layer.sv - scoreboard bench for max_pooling_layer at 4x4, 2 channels, 8 bits
module tb_max_pooling_layer;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int IS = 4;
    localparam int PW = DW * CH;

    logic          clk;
    logic          rst;
    logic          clk_en;
    logic          input_valid;
    logic [PW-1:0] input_data;
    logic [PW-1:0] output_data;
    logic          valid;
    logic          last;

    max_pooling_layer #(
        .D_WIDTH   (DW),
        .CHANNELS  (CH),
        .IMAGE_SIZE(IS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .input_valid(input_valid),
        .input_data (input_data),
        .output_data(output_data),
        .valid      (valid),
        .last       (last)
    );

    typedef struct packed {
        logic [31:0]   cyc;
        logic [PW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [PW-1:0] px [IS*IS];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic          ce_s;
    logic          rst_s;
    exp_t          e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: a new pulse can only form on an enabled, non-reset edge.
    always begin
        @(posedge clk);
        ce_s  = clk_en;
        rst_s = rst;
        cyc   = cyc + 1;
        #1;
        if (!rst_s && ce_s && valid) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_valid: observed valid=1 data=%h at cycle %0d, expected no output", output_data, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                assert (output_data === e.data) else begin
                    n_errors++;
                    $error("FAIL out_data: observed %h expected %h", output_data, e.data);
                end
                n_checks++;
                assert (last === e.last) else begin
                    n_errors++;
                    $error("FAIL out_last: observed %b expected %b (data %h)", last, e.last, e.data);
                end
                n_checks++;
                assert (32'(cyc) === e.cyc) else begin
                    n_errors++;
                    $error("FAIL out_latency: observed cycle %0d expected cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    // Independent window model: max over the 2x2 block ending at pixel p.
    function automatic exp_t model(input int p, input int at_cyc);
        exp_t r;
        int   tl;
        logic [DW-1:0] m;
        tl = p - IS - 1;
        r.data = '0;
        for (int k = 0; k < CH; k++) begin
            m = px[tl][k*DW +: DW];
            if (px[tl+1][k*DW +: DW] > m) m = px[tl+1][k*DW +: DW];
            if (px[p-1][k*DW +: DW]  > m) m = px[p-1][k*DW +: DW];
            if (px[p][k*DW +: DW]    > m) m = px[p][k*DW +: DW];
            r.data[k*DW +: DW] = m;
        end
        r.cyc  = 32'(at_cyc);
        r.last = (p == IS*IS - 1);
        return r;
    endfunction

    task automatic run_frame(input int n_px, input int max_bub, input int freeze_at);
        int nb;
        for (int p = 0; p < n_px; p++) begin
            if (max_bub > 0 && p > 0) begin
                nb = int'($urandom_range(max_bub, 1));
                repeat (nb) begin
                    @(negedge clk);
                    clk_en      = 1'b1;
                    input_valid = 1'b0;
                    input_data  = '1;
                end
            end
            @(negedge clk);
            clk_en      = 1'b1;
            input_valid = 1'b1;
            input_data  = px[p];
            if (((p / IS) % 2 == 1) && ((p % IS) % 2 == 1)) begin
                sb.push_back(model(p, cyc + 1));
            end
            if (p == freeze_at) begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    clk_en      = 1'b0;
                    input_valid = 1'b0;
                    n_checks++;
                    assert (valid === 1'b1) else begin
                        n_errors++;
                        $error("FAIL freeze_valid[%0d]: observed %b expected 1", i, valid);
                    end
                    n_checks++;
                    assert (output_data === 16'h0707) else begin
                        n_errors++;
                        $error("FAIL freeze_data[%0d]: observed %h expected 0707", i, output_data);
                    end
                end
            end
        end
    endtask

    task automatic idle_drain();
        @(negedge clk);
        clk_en      = 1'b1;
        input_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL drain: observed %0d outputs missing, expected 0", sb.size());
        end
    endtask

    task automatic load_ramp();
        for (int p = 0; p < IS*IS; p++) px[p] = {DW'(p), DW'(p)};
    endtask

    initial begin
        rst         = 1'b1;
        clk_en      = 1'b1;
        input_valid = 1'b0;
        input_data  = '0;
        #1;
        n_checks++;
        assert (output_data === '0) else begin n_errors++; $error("FAIL reset_data: observed %h expected 0000", output_data); end
        n_checks++;
        assert (valid === 1'b0) else begin n_errors++; $error("FAIL reset_valid: observed %b expected 0", valid); end
        n_checks++;
        assert (last === 1'b0) else begin n_errors++; $error("FAIL reset_last: observed %b expected 0", last); end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Ramp
        load_ramp();
        run_frame(IS*IS, 0, -1);
        idle_drain();

        // Channel independence
        for (int p = 0; p < IS*IS; p++) px[p] = {DW'(15 - p), DW'(p)};
        run_frame(IS*IS, 0, -1);
        idle_drain();

        // Random bubbles
        load_ramp();
        run_frame(IS*IS, 3, -1);
        idle_drain();

        // Enable freeze after p=7
        run_frame(IS*IS, 0, 7);
        idle_drain();

        // Reset mid-frame after p=6
        run_frame(7, 0, -1);
        @(negedge clk);
        input_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        assert (output_data === '0) else begin n_errors++; $error("FAIL midrst_data: observed %h expected 0000", output_data); end
        n_checks++;
        assert (valid === 1'b0) else begin n_errors++; $error("FAIL midrst_valid: observed %b expected 0", valid); end
        n_checks++;
        assert (last === 1'b0) else begin n_errors++; $error("FAIL midrst_last: observed %b expected 0", last); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_frame(IS*IS, 0, -1);
        idle_drain();

        // Unsigned extremes then zero frame, back-to-back
        for (int p = 0; p < IS*IS; p++) px[p] = (p == 4) ? 16'hFFFF : 16'h7F7F;
        run_frame(IS*IS, 0, -1);
        for (int p = 0; p < IS*IS; p++) px[p] = 16'h0000;
        run_frame(IS*IS, 0, -1);
        idle_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
